dout_display: RTL and testbench

- Downstream consumer of the CPU's output port (Dout, Dval) plus one GPO bit selecting signed interpretation.
- Converts the 8-bit value to sign + 3 BCD digits with an iterative double-dabble, one shift per clock.
- Drives a 4-digit multiplexed, active-low seven-segment display.
- Gives the RPN calculator a readable result without touching the CPU register file.

---
 rtl/dout_display.sv | 196 +++++++++++++++++++
 tb/tb_dout_display.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dout_display.sv
`default_nettype none
// ============================================================================
//  Module   : dout_display
//  Brief    : Shows the CPU output port value as sign + 3 decimal digits on a
//             4-digit multiplexed, active-low seven-segment display. Binary to
//             BCD uses an iterative double-dabble, one shift per clock.
//  Revision : 1.0  initial release
// ============================================================================
module dout_display #(
    parameter int REFRESH_DIV = 50_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_dout,
    input  logic       i_dval,
    input  logic       i_signed,
    output logic [6:0] o_seg,
    output logic [3:0] o_anode,
    output logic       o_busy
);

    localparam int              c_cnt_w   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [6:0]      c_blank   = 7'h7F;
    localparam logic [6:0]      c_minus   = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_last_val;
    logic               r_last_sgn;
    logic               r_pending;
    logic [19:0]        r_shift;
    logic               r_neg;
    logic [2:0]         r_iter;
    logic               r_busy;
    logic [3:0]         r_hund;
    logic [3:0]         r_tens;
    logic [3:0]         r_units;
    logic               r_disp_neg;
    logic [c_cnt_w-1:0] r_scan_cnt;
    logic [1:0]         r_digit;
    logic [6:0]         r_seg;
    logic [3:0]         r_anode;

    logic               w_change;
    logic               w_start;
    logic               w_neg_in;
    logic [7:0]         w_mag;
    logic [19:0]        w_adj;
    logic [6:0]         w_code;

    // Add-3 correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] f_adj3(input logic [3:0] i_n);
        return (i_n >= 4'd5) ? (i_n + 4'd3) : i_n;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit.
    function automatic logic [6:0] f_seg7(input logic [3:0] i_d);
        logic [6:0] v_code;
        case (i_d)
            4'd0:    v_code = 7'h40;
            4'd1:    v_code = 7'h79;
            4'd2:    v_code = 7'h24;
            4'd3:    v_code = 7'h30;
            4'd4:    v_code = 7'h19;
            4'd5:    v_code = 7'h12;
            4'd6:    v_code = 7'h02;
            4'd7:    v_code = 7'h78;
            4'd8:    v_code = 7'h00;
            4'd9:    v_code = 7'h10;
            default: v_code = 7'h7F;
        endcase
        return v_code;
    endfunction

    // Conversion trigger, magnitude of the incoming value and one dabble step.
    always_comb begin
        w_change = i_dval & ((i_dout != r_last_val) | (i_signed != r_last_sgn));
        // Pending work is held off while the display is disabled.
        w_start  = i_dval & (w_change | r_pending);
        w_neg_in = i_signed & i_dout[7];
        // 8 bits suffice: the largest negative magnitude, 128, still fits.
        w_mag    = w_neg_in ? (~i_dout + 8'd1) : i_dout;
        w_adj    = {f_adj3(r_shift[19:16]), f_adj3(r_shift[15:12]),
                    f_adj3(r_shift[11:8]), r_shift[7:0]};
    end

    // Conversion FSM: latch new value, shift 8 times, publish the BCD result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_last_val <= 8'd0;
            r_last_sgn <= 1'b0;
            r_pending  <= 1'b0;
            r_shift    <= 20'd0;
            r_neg      <= 1'b0;
            r_iter     <= 3'd0;
            r_busy     <= 1'b0;
            r_hund     <= 4'd0;
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
            r_disp_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_last_val <= i_dout;
                        r_last_sgn <= i_signed;
                        r_shift    <= {12'd0, w_mag};
                        r_neg      <= w_neg_in;
                        r_iter     <= 3'd0;
                        r_busy     <= 1'b1;
                        r_pending  <= 1'b0;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    // A newer value waits; the latest one is taken back in IDLE.
                    if (w_change) begin
                        r_pending <= 1'b1;
                    end
                    r_shift <= {w_adj[18:0], 1'b0};
                    r_iter  <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_change) begin
                        r_pending <= 1'b1;
                    end
                    r_hund     <= r_shift[19:16];
                    r_tens     <= r_shift[15:12];
                    r_units    <= r_shift[11:8];
                    r_disp_neg <= r_neg;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Digit scan timer: each digit stays selected for REFRESH_DIV clocks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
        end else if (r_scan_cnt == c_cnt_max) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Segment pattern for the currently scanned digit, with leading-zero blanking.
    always_comb begin
        w_code = c_blank;
        case (r_digit)
            2'd0: w_code = f_seg7(r_units);
            2'd1: w_code = ((r_hund == 4'd0) && (r_tens == 4'd0)) ? c_blank : f_seg7(r_tens);
            2'd2: w_code = (r_hund == 4'd0) ? c_blank : f_seg7(r_hund);
            2'd3: w_code = r_disp_neg ? c_minus : c_blank;
            default: w_code = c_blank;
        endcase
    end

    // Registered display drive so segments and anodes switch on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seg   <= c_blank;
            r_anode <= 4'hF;
        end else if (i_dval) begin
            r_seg   <= w_code;
            r_anode <= ~(4'b0001 << r_digit);
        end else begin
            r_seg   <= c_blank;
            r_anode <= 4'hF;
        end
    end

    assign o_seg   = r_seg;
    assign o_anode = r_anode;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dout_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dout_display
//  Brief    : Self-checking bench for dout_display against a decimal model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dout_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dout;
    logic       dval;
    logic       sgn;
    wire  [6:0] seg;
    wire  [3:0] anode;
    wire        busy;

    int n_checks = 0;
    int n_errors = 0;
    int rises    = 0;
    logic busy_q = 1'b0;

    // Model of what the display should show
    logic [7:0] m_last;
    logic       m_last_sgn;
    int         m_mag;
    bit         m_neg;
    logic [6:0] c_codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    dout_display #(.REFRESH_DIV(4)) u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_dout   (dout),
        .i_dval   (dval),
        .i_signed (sgn),
        .o_seg    (seg),
        .o_anode  (anode),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;

    // Count conversions by rising edges of busy
    always @(negedge clk) begin
        if (busy && !busy_q) rises++;
        busy_q = busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int idx);
        case (idx)
            0: return c_codes[m_mag % 10];
            1: return (m_mag < 10) ? 7'h7F : c_codes[(m_mag / 10) % 10];
            2: return (m_mag < 100) ? 7'h7F : c_codes[m_mag / 100];
            default: return m_neg ? 7'h3F : 7'h7F;
        endcase
    endfunction

    task automatic model_set(input logic [7:0] v, input logic s);
        m_last     = v;
        m_last_sgn = s;
        m_neg      = s & v[7];
        m_mag      = m_neg ? (256 - int'(v)) : int'(v);
    endtask

    // Sixteen consecutive cycles cover every digit for four cycles each.
    task automatic scan_check(input string tag);
        logic [3:0] seen;
        int idx;
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (anode)
                4'hE: idx = 0;
                4'hD: idx = 1;
                4'hB: idx = 2;
                4'h7: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                check_eq({tag, "_anode"}, 32'(anode), 32'hE);
            end else begin
                seen[idx] = 1'b1;
                check_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg(idx)));
            end
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'hF);
    endtask

    // Present a value; verify conversion (or absence of one) and the shown digits.
    task automatic apply(input logic [7:0] v, input logic s, input string tag);
        bit conv;
        int w;
        int cnt;
        int r0;
        conv = (v != m_last) || (s != m_last_sgn);
        dout = v;
        sgn  = s;
        dval = 1'b1;
        r0   = rises;
        if (conv) begin
            model_set(v, s);
            w = 0;
            @(negedge clk);
            while (!busy && w < 20) begin
                @(negedge clk);
                w++;
            end
            check_eq({tag, "_start"}, 32'(busy), 32'h1);
            cnt = 0;
            while (busy && cnt < 40) begin
                cnt++;
                @(negedge clk);
            end
            check_eq({tag, "_busylen"}, cnt, 9);
        end else begin
            repeat (12) @(negedge clk);
            check_eq({tag, "_noconv"}, rises - r0, 0);
        end
        repeat (2) @(negedge clk);
        scan_check(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        int w;
        logic [7:0] rv;
        logic       rs;

        rst_n = 1'b0;
        dout  = 8'h00;
        dval  = 1'b0;
        sgn   = 1'b0;
        model_set(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("rst_seg", 32'(seg), 32'h7F);
        check_eq("rst_anode", 32'(anode), 32'hF);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("idle_seg", 32'(seg), 32'h7F);
            check_eq("idle_anode", 32'(anode), 32'hF);
            check_eq("idle_busy", 32'(busy), 32'h0);
        end

        apply(8'h00, 1'b0, "zero");
        apply(8'hFF, 1'b0, "u255");
        apply(8'h80, 1'b1, "m128");
        apply(8'h80, 1'b0, "p128");
        apply(8'h05, 1'b0, "five");
        apply(8'hFB, 1'b1, "m5");

        // Changes during a conversion: only the latest value is converted next.
        r0   = rises;
        dout = 8'h10;
        sgn  = 1'b0;
        @(negedge clk);
        check_eq("pend_busy", 32'(busy), 32'h1);
        @(negedge clk);
        @(negedge clk);
        dout = 8'h20;
        repeat (3) @(negedge clk);
        dout = 8'h63;
        repeat (40) @(negedge clk);
        check_eq("pend_convs", rises - r0, 2);
        check_eq("pend_idle", 32'(busy), 32'h0);
        model_set(8'h63, 1'b0);
        scan_check("pend99");

        // Display disabled: blank, no conversion, old digits return unchanged.
        r0   = rises;
        dval = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) dout = 8'h42;
            check_eq("off_seg", 32'(seg), 32'h7F);
            check_eq("off_anode", 32'(anode), 32'hF);
        end
        check_eq("off_noconv", rises - r0, 0);
        apply(8'h63, 1'b0, "relight");

        for (int k = 0; k < 10; k++) begin
            rv = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            apply(rv, rs, "rand");
        end

        // Reset during the fourth shift cycle of a conversion.
        if (m_last == 8'hC8 && m_last_sgn == 1'b0) apply(8'h01, 1'b0, "pre");
        dout = 8'hC8;
        sgn  = 1'b0;
        dval = 1'b1;
        w = 0;
        @(negedge clk);
        while (!busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("abort_start", 32'(busy), 32'h1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_seg", 32'(seg), 32'h7F);
        check_eq("abort_anode", 32'(anode), 32'hF);
        check_eq("abort_busy", 32'(busy), 32'h0);
        model_set(8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply(8'hC8, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
